serial_word_receiver: RTL

Receiving end of the team's MSB-first serial word link. It collects bits qualified by a per-bit strobe and aligns to word boundaries with a sync marker. Each completed BIT-bit word goes into a one-word holding register, presented on a valid/ready handshake. It sits between the link pins (after the synchroniser) and the consuming datapath. Frame, overflow and optional parity errors are flagged.

---
 rtl/serial_word_receiver_if.sv | 33 +++
 rtl/serial_word_receiver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_word_receiver_if
// Bundles the serial link inputs and the holding-register handshake of
// serial_word_receiver.
//   master : link/consumer side, drives i_serial, i_sdv, i_sync, i_ready
//   slave  : receiver side, drives o_parrel, o_valid, o_perr, o_ovf,
//            o_sync_err, o_busy
// Parameter BIT must match the BIT of the attached receiver.
// -----------------------------------------------------------------------------
interface serial_word_receiver_if #(
  parameter int BIT = 8
) ();
  logic           i_serial;
  logic           i_sdv;
  logic           i_sync;
  logic           i_ready;
  logic [BIT-1:0] o_parrel;
  logic           o_valid;
  logic           o_perr;
  logic           o_ovf;
  logic           o_sync_err;
  logic           o_busy;

  modport master (
    output i_serial, i_sdv, i_sync, i_ready,
    input  o_parrel, o_valid, o_perr, o_ovf, o_sync_err, o_busy
  );

  modport slave (
    input  i_serial, i_sdv, i_sync, i_ready,
    output o_parrel, o_valid, o_perr, o_ovf, o_sync_err, o_busy
  );
endinterface

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
// Receiving end of the MSB-first serial word link. Bits qualified by i_sdv are
// shifted in; i_sync marks the MSB of a word. Completed words are placed in a
// one-word holding register offered on a valid/ready handshake.
// Ports:
//   i_clk   : clock, rising edge
//   i_rstn  : synchronous active-low reset
//   bus     : serial_word_receiver_if.slave
//             (i_serial, i_sdv, i_sync, i_ready in;
//              o_parrel, o_valid, o_perr, o_ovf, o_sync_err, o_busy out)
// Optional feature macro: PARITY_EN
//   defined   -> an even-parity bit follows each word (state S_PAR); o_perr
//                reports XOR of data bits and parity bit.
//   undefined -> no parity bit, o_perr is always 0.
// -----------------------------------------------------------------------------
module serial_word_receiver #(
  parameter int BIT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  serial_word_receiver_if.slave  bus
);
  localparam int CW = $clog2(BIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {S_HUNT = 2'd0, S_SHIFT = 2'd1, S_PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_HUNT = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BIT-1:0] shift_q, shift_d;
  logic [BIT-1:0] parrel_q, parrel_d;
  logic           valid_q, valid_d;
  logic           perr_q, perr_d;
  logic           ovf_q, ovf_d;
  logic           sync_err_q, sync_err_d;
  logic           busy_q, busy_d;

  // Completed-word offer to the holding register for this cycle
  logic           done_s;
  logic [BIT-1:0] word_s;
  logic           word_perr_s;

  // Next-state, shift datapath and holding-register control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    parrel_d    = parrel_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ovf_d       = 1'b0;
    sync_err_d  = 1'b0;
    done_s      = 1'b0;
    word_s      = shift_q;
    word_perr_s = 1'b0;

    if (bus.i_sdv) begin
      case (state_q)
        S_HUNT: begin
          if (bus.i_sync) begin
            shift_d = {{(BIT-1){1'b0}}, bus.i_serial};
            cnt_d   = CW'(1);
            state_d = S_SHIFT;
          end else begin
            state_d = S_HUNT;
          end
        end
        S_SHIFT: begin
          if (bus.i_sync) begin
            // A marker at counter 0 is an ordinary word start
            sync_err_d = (cnt_q != '0);
            shift_d    = {{(BIT-1){1'b0}}, bus.i_serial};
            cnt_d      = CW'(1);
          end else begin
            shift_d = {shift_q[BIT-2:0], bus.i_serial};
            if (cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
              cnt_d   = CW'(BIT);
              state_d = S_PAR;
`else
              done_s  = 1'b1;
              word_s  = {shift_q[BIT-2:0], bus.i_serial};
              cnt_d   = '0;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
`ifdef PARITY_EN
        S_PAR: begin
          if (bus.i_sync) begin
            sync_err_d = 1'b1;
            shift_d    = {{(BIT-1){1'b0}}, bus.i_serial};
            cnt_d      = CW'(1);
          end else begin
            done_s      = 1'b1;
            word_s      = shift_q;
            word_perr_s = ^{shift_q, bus.i_serial};
            cnt_d       = '0;
          end
          state_d = S_SHIFT;
        end
`endif
        default: begin
          state_d = S_HUNT;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Load wins over accept; a full, unaccepted holding register drops the word
    if (done_s && (!valid_q || bus.i_ready)) begin
      parrel_d = word_s;
      perr_d   = word_perr_s;
      valid_d  = 1'b1;
    end else if (done_s) begin
      ovf_d = 1'b1;
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

`ifdef PARITY_EN
    busy_d = ((state_d == S_SHIFT) && (cnt_d != '0)) || (state_d == S_PAR);
`else
    busy_d = (state_d == S_SHIFT) && (cnt_d != '0);
`endif
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_HUNT;
      cnt_q      <= '0;
      shift_q    <= '0;
      parrel_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      parrel_q   <= parrel_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ovf_q      <= ovf_d;
      sync_err_q <= sync_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_parrel   = parrel_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_perr     = perr_q;
  assign bus.o_ovf      = ovf_q;
  assign bus.o_sync_err = sync_err_q;
  assign bus.o_busy     = busy_q;
endmodule
